// File: rtl/vga_vblank_flip_scheduler_pkg.sv
// Shared constants for the vblank flip scheduler: Avalon word addresses
// and the bit positions inside the STATUS and CONTROL registers.
package vga_sched_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_STATUS   = 2'd0;
    localparam logic [1:0] ADDR_CONTROL  = 2'd1;
    localparam logic [1:0] ADDR_FLIP     = 2'd2;
    localparam logic [1:0] ADDR_FRAMECNT = 2'd3;

    // STATUS read layout
    localparam int unsigned ST_SYNC_BIT      = 0;
    localparam int unsigned ST_PENDING_BIT   = 1;
    localparam int unsigned ST_VB_FLAG_BIT   = 2;
    localparam int unsigned ST_FLIP_DONE_BIT = 3;

    // STATUS write-one-to-clear layout; deliberately not aligned with the read layout
    localparam int unsigned ST_W1C_VB_FLAG_BIT   = 1;
    localparam int unsigned ST_W1C_FLIP_DONE_BIT = 2;

    // CONTROL layout
    localparam int unsigned CTL_IRQ_EN_BIT = 0;
    localparam int unsigned CTL_POL_BIT    = 1;

    // FLIP read: front buffer index starts here
    localparam int unsigned FLIP_FRONT_LSB = 16;

endpackage

// File: rtl/vga_vblank_flip_scheduler_if.sv
// Avalon-MM slave bus bundle for the vblank flip scheduler.
//   chipselect/address/read/write/writedata : master -> slave
//   readdata                                : slave -> master, registered
interface vga_vblank_flip_scheduler_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/vga_vblank_flip_scheduler_sync_edge_detect.sv
// Synchronizes the asynchronous vsync input and flags the vblank-start edge.
//   clk, reset : system clock, synchronous active-high reset
//   in_port    : raw asynchronous vsync
//   pol        : 0 = falling edge starts vblank, 1 = rising edge
//   s          : synchronized vsync level
//   vb_evt     : one-cycle pulse on the selected edge of s
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_port,
    input  logic pol,
    output logic s,
    output logic vb_evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Chain and edge register reset to 1 so a low vsync after reset is seen
    // as a fresh falling edge only once it has crossed the whole chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign vb_evt = pol ? (~prev_q & s) : (prev_q & ~s);

endmodule

// File: rtl/vga_vblank_flip_scheduler.sv
// Avalon-MM slave that schedules tear-free frame-buffer flips on vblank start,
// counts frames and raises a maskable per-vblank interrupt.
//   clk, reset   : system clock, synchronous active-high reset
//   bus          : Avalon-MM slave (STATUS, CONTROL, FLIP, FRAMECNT)
//   in_port      : raw asynchronous vsync from the VGA controller
//   irq          : level interrupt, irq_en & vb_flag, registered
//   front_buf    : buffer index scanned out by the VGA reader
//   flip_pending : a flip is queued and waits for the next vblank edge
module vga_vblank_flip_scheduler
    import vga_sched_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned BUF_W       = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    vga_vblank_flip_scheduler_if.slave    bus,
    input  logic                          in_port,
    output logic                          irq,
    output logic [BUF_W-1:0]              front_buf,
    output logic                          flip_pending
);

    logic             s;
    logic             vb_evt;
    logic             wr;
    logic             wr_status;
    logic             wr_control;
    logic             wr_flip;
    logic             wr_framecnt;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;
    logic             irq_q;
    logic [BUF_W-1:0] front_buf_q;
    logic [BUF_W-1:0] target_q;
    logic             flip_pending_q;
    logic             irq_en_q;
    logic             pol_q;
    logic             vb_flag_q;
    logic             flip_done_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             unused_ok;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .pol     (pol_q),
        .s       (s),
        .vb_evt  (vb_evt)
    );

    assign wr          = bus.chipselect & bus.write;
    assign wr_status   = wr && (bus.address == ADDR_STATUS);
    assign wr_control  = wr && (bus.address == ADDR_CONTROL);
    assign wr_flip     = wr && (bus.address == ADDR_FLIP);
    assign wr_framecnt = wr && (bus.address == ADDR_FRAMECNT);

    // Read data is muxed every cycle; the read strobe is not needed.
    assign unused_ok = ^{bus.read, bus.writedata};

    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            ADDR_STATUS: begin
                rd_mux[ST_SYNC_BIT]      = s;
                rd_mux[ST_PENDING_BIT]   = flip_pending_q;
                rd_mux[ST_VB_FLAG_BIT]   = vb_flag_q;
                rd_mux[ST_FLIP_DONE_BIT] = flip_done_q;
            end
            ADDR_CONTROL: begin
                rd_mux[CTL_IRQ_EN_BIT] = irq_en_q;
                rd_mux[CTL_POL_BIT]    = pol_q;
            end
            ADDR_FLIP: begin
                rd_mux[FLIP_FRONT_LSB +: BUF_W] = front_buf_q;
                rd_mux[BUF_W-1:0]               = target_q;
            end
            ADDR_FRAMECNT: begin
                rd_mux[CNT_W-1:0] = frame_cnt_q;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q     <= '0;
            irq_q          <= 1'b0;
            front_buf_q    <= '0;
            target_q       <= '0;
            flip_pending_q <= 1'b0;
            irq_en_q       <= 1'b0;
            pol_q          <= 1'b0;
            vb_flag_q      <= 1'b0;
            flip_done_q    <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            readdata_q <= rd_mux;
            irq_q      <= irq_en_q & vb_flag_q;

            if (wr_control) begin
                irq_en_q <= bus.writedata[CTL_IRQ_EN_BIT];
                pol_q    <= bus.writedata[CTL_POL_BIT];
            end

            // Sticky flags: a vblank in the same cycle beats a W1C.
            if (vb_evt) begin
                vb_flag_q <= 1'b1;
            end else if (wr_status && bus.writedata[ST_W1C_VB_FLAG_BIT]) begin
                vb_flag_q <= 1'b0;
            end

            if (vb_evt && flip_pending_q) begin
                flip_done_q <= 1'b1;
            end else if (wr_status && bus.writedata[ST_W1C_FLIP_DONE_BIT]) begin
                flip_done_q <= 1'b0;
            end

            // The edge applies only the target queued before this cycle; a FLIP
            // write in the same cycle stays queued for the next frame.
            if (vb_evt && flip_pending_q) begin
                front_buf_q <= target_q;
            end

            if (wr_flip) begin
                target_q       <= bus.writedata[BUF_W-1:0];
                flip_pending_q <= 1'b1;
            end else if (vb_evt) begin
                flip_pending_q <= 1'b0;
            end

            if (wr_framecnt) begin
                frame_cnt_q <= '0;
            end else if (vb_evt) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;
    assign front_buf    = front_buf_q;
    assign flip_pending = flip_pending_q;

endmodule

// File: tb/tb_vga_vblank_flip_scheduler.sv
// Directed self-checking bench for vga_vblank_flip_scheduler. A second
// instance with a 4-bit frame counter exercises counter wrap-around.
module tb_vga_vblank_flip_scheduler;
    import vga_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic in_port;
    logic irq;
    logic [0:0] front_buf;
    logic flip_pending;

    logic in_port2;
    logic irq2;
    logic [0:0] front_buf2;
    logic flip_pending2;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;

    vga_vblank_flip_scheduler_if bus ();
    vga_vblank_flip_scheduler_if bus2 ();

    vga_vblank_flip_scheduler #(
        .SYNC_STAGES (2),
        .BUF_W       (1),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .in_port      (in_port),
        .irq          (irq),
        .front_buf    (front_buf),
        .flip_pending (flip_pending)
    );

    vga_vblank_flip_scheduler #(
        .SYNC_STAGES (2),
        .BUF_W       (1),
        .CNT_W       (4)
    ) dut_wrap (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus2.slave),
        .in_port      (in_port2),
        .irq          (irq2),
        .front_buf    (front_buf2),
        .flip_pending (flip_pending2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        tick();
        data           = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    initial begin
        bus.chipselect  = 1'b0;
        bus.address     = 2'd0;
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.writedata   = '0;
        bus2.chipselect = 1'b0;
        bus2.address    = ADDR_FRAMECNT;
        bus2.read       = 1'b0;
        bus2.write      = 1'b0;
        bus2.writedata  = '0;
        in_port  = 1'b1;
        in_port2 = 1'b1;

        // 1: reset with vsync toggling
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_port = ~in_port;
            tick();
        end
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_front_buf", {31'b0, front_buf}, 32'h0);
        check("rst_flip_pending", {31'b0, flip_pending}, 32'h0);
        in_port = 1'b1;
        reset   = 1'b0;
        ticks(4);
        bus_read(ADDR_FRAMECNT, rd);
        check("rst_framecnt", rd, 32'h0);
        bus_read(ADDR_STATUS, rd);
        check("rst_status", rd, 32'h1);

        // 2: falling edge, pol=0
        in_port = 1'b0;
        ticks(3);
        bus_read(ADDR_STATUS, rd);
        check("vb_status", rd, 32'h4);
        check("vb_irq_masked", {31'b0, irq}, 32'h0);
        bus_read(ADDR_FRAMECNT, rd);
        check("vb_framecnt1", rd, 32'h1);
        in_port = 1'b1;
        ticks(3);
        bus_read(ADDR_FRAMECNT, rd);
        check("rise_no_evt", rd, 32'h1);

        // 3: mid-frame flip request
        bus_write(ADDR_FLIP, 32'h1);
        check("flip_pending_set", {31'b0, flip_pending}, 32'h1);
        check("flip_front_hold", {31'b0, front_buf}, 32'h0);
        bus_read(ADDR_FLIP, rd);
        check("flip_rd_target", rd, 32'h1);
        in_port = 1'b0;
        ticks(2);
        check("flip_before_edge", {31'b0, front_buf}, 32'h0);
        tick();
        check("flip_applied", {31'b0, front_buf}, 32'h1);
        check("flip_pending_clr", {31'b0, flip_pending}, 32'h0);
        bus_read(ADDR_STATUS, rd);
        check("flip_status", rd, 32'hC);
        in_port = 1'b1;
        ticks(3);
        bus_read(ADDR_FLIP, rd);
        check("flip_rd_front", rd, 32'h0001_0001);

        // 4a: FLIP write on the event cycle, nothing pending before
        in_port = 1'b0;
        ticks(2);
        bus_write(ADDR_FLIP, 32'h0);
        check("flipevt_front", {31'b0, front_buf}, 32'h1);
        check("flipevt_pending", {31'b0, flip_pending}, 32'h1);
        in_port = 1'b1;
        ticks(3);
        in_port = 1'b0;
        ticks(3);
        check("flipevt_next_front", {31'b0, front_buf}, 32'h0);
        check("flipevt_next_pend", {31'b0, flip_pending}, 32'h0);

        // 4b: FLIP write on the event cycle with an older target pending
        in_port = 1'b1;
        ticks(3);
        bus_write(ADDR_FLIP, 32'h1);
        in_port = 1'b0;
        ticks(2);
        bus_write(ADDR_FLIP, 32'hFFFF_FFF0);
        check("oldtgt_front", {31'b0, front_buf}, 32'h1);
        check("oldtgt_pending", {31'b0, flip_pending}, 32'h1);
        bus_read(ADDR_FLIP, rd);
        check("oldtgt_rd", rd, 32'h0001_0000);
        in_port = 1'b1;
        ticks(3);
        in_port = 1'b0;
        ticks(3);
        check("oldtgt_next_front", {31'b0, front_buf}, 32'h0);

        // write with chipselect low is ignored
        bus.chipselect = 1'b0;
        bus.write      = 1'b1;
        bus.address    = ADDR_FLIP;
        bus.writedata  = 32'h1;
        tick();
        bus.write      = 1'b0;
        check("nocs_ignored", {31'b0, flip_pending}, 32'h0);
        bus_read(ADDR_FRAMECNT, rd);
        check("framecnt6", rd, 32'h6);

        // 5: interrupt
        bus_write(ADDR_STATUS, 32'h6);
        bus_write(ADDR_CONTROL, 32'h1);
        bus_read(ADDR_CONTROL, rd);
        check("ctl_rd", rd, 32'h1);
        check("irq_idle", {31'b0, irq}, 32'h0);
        in_port = 1'b1;
        ticks(3);
        in_port = 1'b0;
        ticks(3);
        check("irq_lag", {31'b0, irq}, 32'h0);
        tick();
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_write(ADDR_STATUS, 32'h2);
        check("irq_w1c_lag", {31'b0, irq}, 32'h1);
        tick();
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // W1C on the event cycle: set wins
        in_port = 1'b1;
        ticks(3);
        in_port = 1'b0;
        ticks(2);
        bus_write(ADDR_STATUS, 32'h2);
        bus_read(ADDR_STATUS, rd);
        check("w1c_vs_evt", rd, 32'h4);
        check("w1c_vs_evt_irq", {31'b0, irq}, 32'h1);

        // FRAMECNT clear on the event cycle: clear wins
        in_port = 1'b1;
        ticks(3);
        in_port = 1'b0;
        ticks(2);
        bus_write(ADDR_FRAMECNT, 32'h1234);
        bus_read(ADDR_FRAMECNT, rd);
        check("cntclr_vs_evt", rd, 32'h0);

        // pol=1: rising edge starts vblank
        bus_write(ADDR_STATUS, 32'h2);
        bus_write(ADDR_CONTROL, 32'h3);
        bus_read(ADDR_CONTROL, rd);
        check("pol_ctl_rd", rd, 32'h3);
        in_port = 1'b1;
        ticks(3);
        bus_read(ADDR_STATUS, rd);
        check("pol_status", rd, 32'h5);
        bus_read(ADDR_FRAMECNT, rd);
        check("pol_cnt", rd, 32'h1);
        in_port = 1'b0;
        ticks(3);
        bus_read(ADDR_FRAMECNT, rd);
        check("pol_fall_ignored", rd, 32'h1);

        // reset mid-operation discards a pending flip and re-primes the synchronizer
        bus_write(ADDR_FLIP, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_pending", {31'b0, flip_pending}, 32'h0);
        check("mid_rst_front", {31'b0, front_buf}, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        check("mid_rst_readdata", bus.readdata, 32'h0);
        ticks(2);
        bus_read(ADDR_FRAMECNT, rd);
        check("reprime_quiet", rd, 32'h0);
        bus_read(ADDR_FRAMECNT, rd);
        check("reprime_evt", rd, 32'h1);

        // 6: counter wrap on the 4-bit instance
        for (int i = 0; i < 15; i++) begin
            in_port2 = 1'b0;
            tick();
            in_port2 = 1'b1;
            tick();
        end
        ticks(3);
        check("wrap_max", bus2.readdata, 32'hF);
        in_port2 = 1'b0;
        tick();
        in_port2 = 1'b1;
        ticks(3);
        check("wrap_zero", bus2.readdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
